// File: rtl/rd_multi_read_sequencer_if.sv
// ---------------------------------------------------------------------------
// rd_multi_read_sequencer_if
// Purpose : Groups the command, mutex, flush, memory-read and completion
//           signals of the multi-read sequencer into one bundle.
// Modports:
//   master - command/decode side plus memory port model (drives commands,
//            mutex_busy, flush and read responses; observes the rest)
//   slave  - the sequencer itself
// Signals : cmd_valid/cmd_ready/cmd_count/cmd_size/cmd_linear/cmd_descending/
//           cmd_mutex_req, mutex_busy, flush, rd_req/rd_address/rd_length/
//           rd_ready/rd_data/rd_fault, done/fault/result/result_count/waiting
// ---------------------------------------------------------------------------
interface rd_multi_read_sequencer_if #(
    parameter int MAX_READS = 4,
    parameter int ADDR_W    = 32,
    parameter int MUTEX_W   = 11
) ();
    localparam int CNT_W = $clog2(MAX_READS + 1);

    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [CNT_W-1:0]          cmd_count;
    logic [1:0]                cmd_size;
    logic [ADDR_W-1:0]         cmd_linear;
    logic                      cmd_descending;
    logic [MUTEX_W-1:0]        cmd_mutex_req;
    logic [MUTEX_W-1:0]        mutex_busy;
    logic                      flush;

    logic                      rd_req;
    logic [ADDR_W-1:0]         rd_address;
    logic [1:0]                rd_length;
    logic                      rd_ready;
    logic [63:0]               rd_data;
    logic                      rd_fault;

    logic                      done;
    logic                      fault;
    logic [64*MAX_READS-1:0]   result;
    logic [CNT_W-1:0]          result_count;
    logic                      waiting;

    modport master (
        output cmd_valid, cmd_count, cmd_size, cmd_linear, cmd_descending,
               cmd_mutex_req, mutex_busy, flush, rd_ready, rd_data, rd_fault,
        input  cmd_ready, rd_req, rd_address, rd_length, done, fault, result,
               result_count, waiting
    );

    modport slave (
        input  cmd_valid, cmd_count, cmd_size, cmd_linear, cmd_descending,
               cmd_mutex_req, mutex_busy, flush, rd_ready, rd_data, rd_fault,
        output cmd_ready, rd_req, rd_address, rd_length, done, fault, result,
               result_count, waiting
    );
endinterface

// File: rtl/rd_multi_read_sequencer.sv
// ---------------------------------------------------------------------------
// rd_multi_read_sequencer
// Purpose : Accepts one read command describing up to MAX_READS consecutive
//           memory reads, waits for its mutex resources to clear, issues the
//           reads one at a time over a req/ready handshake and gathers the
//           returned data into a result buffer, then pulses done.
// Ports   :
//   clk    - clock
//   rst_n  - asynchronous active-low reset
//   bus    - rd_multi_read_sequencer_if.slave (command, mutex, flush,
//            memory read port and completion/result signals)
// ---------------------------------------------------------------------------
module rd_multi_read_sequencer #(
    parameter int MAX_READS = 4,
    parameter int ADDR_W    = 32,
    parameter int MUTEX_W   = 11
) (
    input  logic                         clk,
    input  logic                         rst_n,
    rd_multi_read_sequencer_if.slave     bus
);
    localparam int CNT_W = $clog2(MAX_READS + 1);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_MUTEX_WAIT = 2'd1,
        S_ISSUE      = 2'd2,
        S_DONE       = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_next;

    logic [CNT_W-1:0]          r_count;
    logic [CNT_W-1:0]          r_idx;
    logic [CNT_W-1:0]          r_result_count;
    logic [1:0]                r_size;
    logic                      r_desc;
    logic [MUTEX_W-1:0]        r_mutex;
    logic [ADDR_W-1:0]         r_addr;
    logic [64*MAX_READS-1:0]   r_result;
    logic                      r_fault;

    logic                      w_accept;
    logic                      w_rd_hs;
    logic                      w_last;
    logic                      w_mutex_clear;
    logic [CNT_W-1:0]          w_clamped;
    logic [ADDR_W-1:0]         w_step;

    // Zero-extend returned data to the access size.
    function automatic logic [63:0] f_mask(input logic [63:0] d, input logic [1:0] sz);
        logic [63:0] m;
        case (sz)
            2'd0:    m = {56'd0, d[7:0]};
            2'd1:    m = {48'd0, d[15:0]};
            2'd2:    m = {32'd0, d[31:0]};
            default: m = d;
        endcase
        return m;
    endfunction

    // Flush outranks everything: a command offered in the same cycle is not
    // taken and a coinciding read completion is dropped.
    assign w_accept      = bus.cmd_valid && (r_state == S_IDLE) && !bus.flush;
    assign w_rd_hs       = (r_state == S_ISSUE) && bus.rd_ready && !bus.flush;
    assign w_last        = (r_idx == (r_count - CNT_W'(1)));
    assign w_mutex_clear = ((bus.mutex_busy & r_mutex) == '0);
    assign w_clamped     = (bus.cmd_count > CNT_W'(MAX_READS)) ? CNT_W'(MAX_READS)
                                                               : bus.cmd_count;
    assign w_step        = ADDR_W'(1) << r_size;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (bus.flush) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        w_next = (w_clamped == '0) ? S_DONE : S_MUTEX_WAIT;
                    end
                end
                S_MUTEX_WAIT: begin
                    if (w_mutex_clear) begin
                        w_next = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_rd_hs && (bus.rd_fault || w_last)) begin
                        w_next = S_DONE;
                    end
                end
                default: begin
                    w_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count        <= '0;
            r_idx          <= '0;
            r_result_count <= '0;
            r_size         <= '0;
            r_desc         <= 1'b0;
            r_mutex        <= '0;
            r_addr         <= '0;
            r_result       <= '0;
            r_fault        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_count        <= w_clamped;
                r_idx          <= '0;
                r_result_count <= '0;
                r_size         <= bus.cmd_size;
                r_desc         <= bus.cmd_descending;
                r_mutex        <= bus.cmd_mutex_req;
                r_addr         <= bus.cmd_linear;
                r_result       <= '0;
                r_fault        <= 1'b0;
            end
            if (w_rd_hs) begin
                if (bus.rd_fault) begin
                    r_fault <= 1'b1;
                end else begin
                    for (int i = 0; i < MAX_READS; i++) begin
                        if (r_idx == CNT_W'(i)) begin
                            r_result[64*i +: 64] <= f_mask(bus.rd_data, r_size);
                        end
                    end
                    r_result_count <= r_result_count + CNT_W'(1);
                    // Address arithmetic wraps modulo 2^ADDR_W by design.
                    r_addr <= r_desc ? (r_addr - w_step) : (r_addr + w_step);
                    if (!w_last) begin
                        r_idx <= r_idx + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign bus.cmd_ready    = (r_state == S_IDLE);
    assign bus.rd_req       = (r_state == S_ISSUE);
    assign bus.rd_address   = r_addr;
    assign bus.rd_length    = r_size;
    assign bus.done         = (r_state == S_DONE);
    assign bus.fault        = r_fault;
    assign bus.result       = r_result;
    assign bus.result_count = r_result_count;
    assign bus.waiting      = (r_state == S_MUTEX_WAIT) || (r_state == S_ISSUE);

endmodule

// File: tb/tb_rd_multi_read_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rd_multi_read_sequencer
// Scoreboard bench: the driver computes each command's expected read
// addresses and final results from the behavioural rules and queues them;
// a negedge monitor pops and compares on every read handshake and done.
// ---------------------------------------------------------------------------
module tb_rd_multi_read_sequencer;
    localparam int MAX_READS = 4;
    localparam int ADDR_W    = 32;
    localparam int MUTEX_W   = 11;
    localparam int CNT_W     = $clog2(MAX_READS + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rd_multi_read_sequencer_if #(.MAX_READS(MAX_READS), .ADDR_W(ADDR_W), .MUTEX_W(MUTEX_W)) bus ();

    rd_multi_read_sequencer #(.MAX_READS(MAX_READS), .ADDR_W(ADDR_W), .MUTEX_W(MUTEX_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [1:0]        len;
    } rd_exp_t;

    typedef struct {
        logic [64*MAX_READS-1:0] res;
        int                      cnt;
        logic                    flt;
    } done_exp_t;

    rd_exp_t   rd_q[$];
    done_exp_t done_q[$];
    logic [63:0] data_plan[$];

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endfunction

    // Value seen on the bus for an access of 2^size bytes.
    function automatic logic [63:0] model_mask(logic [63:0] d, int size);
        int bits;
        bits = 8 * (1 << size);
        if (bits >= 64) return d;
        return d % (64'd1 << bits);
    endfunction

    // Monitor: compares whatever the DUT presents against queued expectations.
    always @(negedge clk) begin
        rd_exp_t   re;
        done_exp_t de;
        if (rst_n === 1'b1) begin
            if (bus.rd_req && bus.rd_ready) begin
                if (rd_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_read: got address 0x%0h, expected no request", bus.rd_address);
                end else begin
                    re = rd_q.pop_front();
                    chk("rd_address", 64'(bus.rd_address), 64'(re.addr));
                    chk("rd_length", 64'(bus.rd_length), 64'(re.len));
                end
            end
            if (bus.done) begin
                if (done_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got done=1, expected 0");
                end else begin
                    de = done_q.pop_front();
                    for (int s = 0; s < MAX_READS; s++)
                        chk($sformatf("result_slot%0d", s), bus.result[64*s +: 64], de.res[64*s +: 64]);
                    chk("result_count", 64'(bus.result_count), 64'(de.cnt));
                    chk("fault", 64'(bus.fault), 64'(de.flt));
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.rd_ready = 1'b0;
        bus.rd_fault = 1'b0;
        bus.flush = 1'b0;
        @(posedge clk); #1;
        rd_q.delete();
        done_q.delete();
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Issues one command and plays the memory side. fault_at / flush_at give the
    // read index that faults / coincides with flush (-1 for none).
    task automatic run_cmd(int count, int size, logic [ADDR_W-1:0] linear, bit desc,
                           logic [MUTEX_W-1:0] mreq, int busy_cyc, int fault_at,
                           int flush_at, int wmax);
        int n, nreq, stored, t, w;
        bit flt, flushed;
        logic [ADDR_W-1:0] a;
        logic [64*MAX_READS-1:0] res;
        logic [63:0] dat [MAX_READS];

        // Reference expectation
        n = (count > MAX_READS) ? MAX_READS : count;
        a = linear; res = '0; stored = 0; flt = 0; flushed = 0; nreq = 0;
        for (int k = 0; k < n; k++) begin
            dat[k] = (data_plan.size() != 0) ? data_plan.pop_front() : {$urandom, $urandom};
            rd_q.push_back('{a, 2'(size)});
            nreq++;
            if (k == flush_at) begin flushed = 1; break; end
            if (k == fault_at) begin flt = 1; break; end
            res[64*k +: 64] = model_mask(dat[k], size);
            stored++;
            a = desc ? a - ADDR_W'(1 << size) : a + ADDR_W'(1 << size);
        end
        if (!flushed) done_q.push_back('{res, stored, flt});

        t = 0;
        while (!bus.cmd_ready && t < 50) begin @(posedge clk); #1; t++; end
        if (!bus.cmd_ready) begin
            chk("cmd_ready_timeout", 64'(bus.cmd_ready), 64'd1);
            do_reset();
            return;
        end
        bus.cmd_valid      = 1'b1;
        bus.cmd_count      = CNT_W'(count);
        bus.cmd_size       = 2'(size);
        bus.cmd_linear     = linear;
        bus.cmd_descending = desc;
        bus.cmd_mutex_req  = mreq;
        bus.mutex_busy     = (busy_cyc > 0) ? mreq : ~mreq;
        @(posedge clk); #1;
        bus.cmd_valid  = 1'b0;
        bus.cmd_count  = CNT_W'($urandom);
        bus.cmd_linear = $urandom;

        if (n == 0) begin
            chk("zero_done_latency", 64'(bus.done), 64'd1);
            chk("zero_no_req", 64'(bus.rd_req), 64'd0);
            @(posedge clk); #1;
            chk("zero_back_idle", 64'(bus.cmd_ready), 64'd1);
            return;
        end

        for (int i = 0; i < busy_cyc; i++) begin
            chk("stall_waiting", 64'(bus.waiting), 64'd1);
            chk("stall_no_req", 64'(bus.rd_req), 64'd0);
            bus.rd_ready = 1'b1;   // must be ignored without rd_req
            bus.rd_data  = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        bus.rd_ready   = 1'b0;
        bus.mutex_busy = ~mreq;
        chk("clear_cycle_no_req", 64'(bus.rd_req), 64'd0);
        @(posedge clk); #1;
        chk("req_after_clear", 64'(bus.rd_req), 64'd1);

        for (int k = 0; k < nreq; k++) begin
            t = 0;
            while (!bus.rd_req && t < 50) begin @(posedge clk); #1; t++; end
            if (!bus.rd_req) begin
                chk("rd_req_timeout", 64'(bus.rd_req), 64'd1);
                do_reset();
                return;
            end
            w = $urandom_range(0, wmax);
            repeat (w) begin
                @(posedge clk); #1;
                chk("rd_req_held", 64'(bus.rd_req), 64'd1);
            end
            bus.rd_ready = 1'b1;
            bus.rd_data  = dat[k];
            bus.rd_fault = (k == fault_at);
            bus.flush    = (k == flush_at);
            @(posedge clk); #1;
            bus.rd_ready = 1'b0;
            bus.rd_fault = 1'b0;
            bus.flush    = 1'b0;
            bus.rd_data  = {$urandom, $urandom};
            if (k == flush_at) begin
                chk("flush_idle", 64'(bus.cmd_ready), 64'd1);
                chk("flush_req_drop", 64'(bus.rd_req), 64'd0);
                chk("flush_done_low", 64'(bus.done), 64'd0);
                chk("flush_result_count", 64'(bus.result_count), 64'(stored));
                return;
            end
            if (k == nreq - 1) begin
                chk("done_latency", 64'(bus.done), 64'd1);
                chk("done_no_req", 64'(bus.rd_req), 64'd0);
            end
        end
        @(posedge clk); #1;
        chk("back_to_idle", 64'(bus.cmd_ready), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, sz, fa, fl;
        bus.cmd_valid = 0; bus.cmd_count = 0; bus.cmd_size = 0; bus.cmd_linear = 0;
        bus.cmd_descending = 0; bus.cmd_mutex_req = 0; bus.mutex_busy = 0; bus.flush = 0;
        bus.rd_ready = 0; bus.rd_data = 0; bus.rd_fault = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        chk("rst_rd_req", 64'(bus.rd_req), 64'd0);
        chk("rst_rd_address", 64'(bus.rd_address), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_fault", 64'(bus.fault), 64'd0);
        chk("rst_result_count", 64'(bus.result_count), 64'd0);
        chk("rst_waiting", 64'(bus.waiting), 64'd0);
        for (int s = 0; s < MAX_READS; s++) chk("rst_result", bus.result[64*s +: 64], 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: two ascending dwords, memory always ready
        data_plan.push_back(64'hAABBCCDD_11223344);
        data_plan.push_back(64'h00000000_55667788);
        run_cmd(2, 2, 32'h1000, 0, 11'h001, 0, -1, -1, 0);
        chk("t1_slot0", bus.result[63:0], 64'h11223344);
        chk("t1_slot1", bus.result[127:64], 64'h55667788);
        chk("t1_count", 64'(bus.result_count), 64'd2);
        chk("t1_fault", 64'(bus.fault), 64'd0);

        // 2: descending qwords wrapping below zero
        run_cmd(3, 3, 32'h4, 1, 11'h002, 0, -1, -1, 1);
        chk("t2_final_addr", 64'(bus.rd_address), 64'hFFFFFFEC);

        // 3: rep-ignore
        run_cmd(0, 1, 32'h200, 0, 11'h001, 0, -1, -1, 0);
        chk("t3_count", 64'(bus.result_count), 64'd0);

        // 4: mutex stall for 5 cycles
        run_cmd(2, 1, 32'h300, 0, 11'h004, 5, -1, -1, 1);

        // 5: fault on the second of four reads
        run_cmd(4, 2, 32'h400, 0, 11'h008, 0, 1, -1, 0);
        chk("t5_fault", 64'(bus.fault), 64'd1);
        chk("t5_count", 64'(bus.result_count), 64'd1);

        // 6: flush coinciding with the second read completion
        run_cmd(3, 0, 32'h500, 0, 11'h010, 0, -1, 1, 0);

        // flush together with cmd_valid in IDLE must not accept
        bus.cmd_valid = 1'b1; bus.cmd_count = 3'd2; bus.flush = 1'b1; bus.mutex_busy = '0;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0; bus.flush = 1'b0;
        chk("flush_blocks_accept", 64'(bus.cmd_ready), 64'd1);
        chk("flush_blocks_waiting", 64'(bus.waiting), 64'd0);

        // reset mid-ISSUE after one stored read
        rd_q.push_back('{32'h2000, 2'd2});
        bus.cmd_valid = 1'b1; bus.cmd_count = 3'd3; bus.cmd_size = 2'd2;
        bus.cmd_linear = 32'h2000; bus.cmd_descending = 1'b0;
        bus.cmd_mutex_req = 11'h001; bus.mutex_busy = '0;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk("rstmid_req", 64'(bus.rd_req), 64'd1);
        bus.rd_ready = 1'b1; bus.rd_data = 64'h0123456789ABCDEF;
        @(posedge clk); #1;
        bus.rd_ready = 1'b0;
        chk("rstmid_pre_count", 64'(bus.result_count), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_req_zero", 64'(bus.rd_req), 64'd0);
        chk("rstmid_addr_zero", 64'(bus.rd_address), 64'd0);
        chk("rstmid_count_zero", 64'(bus.result_count), 64'd0);
        chk("rstmid_slot0_zero", bus.result[63:0], 64'd0);
        chk("rstmid_waiting_zero", 64'(bus.waiting), 64'd0);
        chk("rstmid_done_zero", 64'(bus.done), 64'd0);
        chk("rstmid_fault_zero", 64'(bus.fault), 64'd0);
        chk("rstmid_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // randomized commands
        for (int it = 0; it < 40; it++) begin
            cnt = $urandom_range(0, 7);
            sz  = $urandom_range(0, 3);
            fa  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1;
            fl  = (fa < 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1;
            run_cmd(cnt, sz, $urandom, 1'($urandom), MUTEX_W'($urandom) | 11'h001,
                    $urandom_range(0, 3), fa, fl, 2);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("rd_queue_drained", 64'(rd_q.size()), 64'd0);
        chk("done_queue_drained", 64'(done_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rd_multi_read_sequencer.md
Name: rd_multi_read_sequencer

Overview:
- Parametrised successor to the read-stage command logic.
- Accepts one read command describing up to MAX_READS consecutive memory reads (word/dword/qword, ascending or descending stride), waits for its mutex resources to clear, then issues the reads one at a time over a req/ready handshake.
- Collects the returned data into a result buffer and signals completion.
- Sits between the read-stage command decode and the memory read port; replaces hand-sequenced multi-read commands (descriptor, IRET/RET stack frames, string reads).

Parameters:
- MAX_READS, 4, maximum reads per command; result buffer depth.
- ADDR_W, 32, linear address width.
- MUTEX_W, 11, number of mutex resource bits.
- CNT_W (localparam), clog2(MAX_READS+1), width of count fields.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  sequencer idle; command accepted when cmd_valid && cmd_ready.
- cmd_count  in  CNT_W  number of reads; 0 = rep-ignore (no reads).
- cmd_size  in  2  0=byte, 1=word, 2=dword, 3=qword.
- cmd_linear  in  ADDR_W  address of first read.
- cmd_descending  in  1  1 = address decrements by size after each read.
- cmd_mutex_req  in  MUTEX_W  resources this command depends on.
- mutex_busy  in  MUTEX_W  resources currently held by later stages.
- flush  in  1  pipeline flush; aborts the current command.
- rd_req  out  1  read request.
- rd_address  out  ADDR_W  read linear address.
- rd_length  out  2  copy of cmd_size.
- rd_ready  in  1  read completes this cycle.
- rd_data  in  64  read data, valid with rd_ready.
- rd_fault  in  1  read faulted; qualified by rd_ready.
- done  out  1  one-cycle completion pulse.
- fault  out  1  completed command ended on a fault; stable with the results.
- result  out  64*MAX_READS  slot i at bits [64i+63:64i], zero-extended to size.
- result_count  out  CNT_W  number of valid slots.
- waiting  out  1  high in MUTEX_WAIT or ISSUE.

Behaviour:
- States: IDLE, MUTEX_WAIT, ISSUE, DONE.
- Reset: state IDLE; rd_req=0, rd_address=0, done=0, fault=0, result=0, result_count=0, waiting=0, internal index=0.
- cmd_ready=1 exactly when state==IDLE, including during reset.
- IDLE, on accept:
  - Latch the command; clear result, result_count and fault.
  - Clamp cmd_count to MAX_READS.
  - cmd_count==0: go to DONE.
  - Otherwise go to MUTEX_WAIT.
- MUTEX_WAIT: when (mutex_busy & latched mutex_req)==0, go to ISSUE next cycle. This is evaluated every cycle, so no deadline applies.
- ISSUE:
  - rd_req=1; rd_address and rd_length are registered and held stable until rd_ready.
  - On rd_ready with rd_fault=0:
    - Write rd_data masked to size into slot[index]; result_count++.
    - Address ±= (1<<size), modulo 2^ADDR_W (wrap permitted).
    - If this was the last read, go to DONE; otherwise index++ and stay in ISSUE.
  - Back-to-back: rd_req stays high and the new address appears the cycle after rd_ready.
  - On rd_ready with rd_fault=1: set fault, discard data, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
  - result, result_count and fault hold until the next accepted command.
- Latency:
  - count=0: done 1 cycle after accept.
  - count=N with no mutex stall and 0-wait memory: first rd_req 2 cycles after accept; done 1 cycle after the last rd_ready.
- flush:
  - From any state, go to IDLE next cycle.
  - rd_req drops the following cycle; done is not pulsed.
  - A simultaneous rd_ready is ignored: flush wins and data is not stored.
  - result_count reflects only reads stored before the flush.
  - flush together with cmd_valid in IDLE: the command is not accepted.
- rd_ready while rd_req=0 is ignored.
- Reset asserted mid-command returns all state and outputs to reset values immediately.

Test Plan:
1. Accept count=2, size=2, linear=0x1000, ascending, mutex clear; rd_ready held 1 with data 0xAABBCCDD_11223344 then 0x55667788 -> rd_address 0x1000 then 0x1004; slot0=0x11223344, slot1=0x55667788; result_count=2; done pulses once; fault=0.
2. Accept count=3, size=3, linear=0x00000004, descending -> addresses 0x4, 0xFFFFFFFC, 0xFFFFFFF4 (wrap); done after the third rd_ready.
3. Accept count=0 -> no rd_req; done 1 cycle after accept; result_count=0.
4. cmd_mutex_req=0x004 with mutex_busy=0x004 for 5 cycles -> waiting=1 and rd_req=0 throughout; rd_req asserts 1 cycle after busy clears.
5. count=4, rd_fault with the second rd_ready -> fault=1; result_count=1; done pulses; no third request.
6. flush coincident with the second rd_ready of count=3 -> no done; result_count=1; next cycle IDLE with cmd_ready=1; rst_n pulsed mid-ISSUE -> all outputs zero.
